id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage feeding the 32-bit ALU (op1, op2, alu_op).
//  Captures decoded instructions and applies EX/MEM and MEM/WB forwarding to rs1/rs2.
//  Detects load-use hazards, back-pressures decode and inserts a bubble.
//  Valid/ready handshake on both sides; flush on taken branch/jump.
// PARAMETERS
//  XLEN  32  datapath width
//  REGW  5   register index width
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     asynchronous, active-high reset
//  flush            in   1     kill held and incoming instruction
//  id_valid         in   1     decode presents an instruction
//  id_ready         out  1     stage accepts the decode instruction this cycle
//  id_rs1,id_rs2    in   REGW  source register indices
//  id_rs1_data      in   XLEN  regfile read data for rs1
//  id_rs2_data      in   XLEN  regfile read data for rs2
//  id_imm,id_pc     in   XLEN  immediate and instruction PC
//  id_use_imm       in   1     op2 = imm, else rs2
//  id_use_pc        in   1     op1 = pc, else rs1
//  id_alu_op        in   4     ALU opcode (AND=0000 OR=0001 ADD=0010 SUB=0110 ...)
//  id_rd            in   REGW  destination register
//  id_reg_write     in   1     instruction writes rd
//  id_mem_read      in   1     instruction is a load
//  exmem_rd,exmem_reg_write,exmem_result  in  REGW/1/XLEN  EX/MEM producer
//  memwb_rd,memwb_reg_write,memwb_result  in  REGW/1/XLEN  MEM/WB producer
//  ex_valid         out  1     ALU-side instruction valid
//  ex_ready         in   1     downstream accepts this cycle
//  ex_op1,ex_op2    out  XLEN  forwarded/selected ALU operands
//  ex_store_data    out  XLEN  forwarded rs2 value (store data)
//  ex_alu_op        out  4     registered ALU opcode
//  ex_rd,ex_reg_write,ex_mem_read  out  REGW/1/1  registered control
//  load_use_stall   out  1     hazard indicator (combinational)
// BEHAVIOUR
//  - Reset: all registers 0; ex_valid=0, ex_alu_op=4'b0000, ex_rd=0, ex_reg_write=0, ex_mem_read=0.
//  - Latency: one cycle from accepted id_* to ex_* registers; forwarding mux is combinational.
//  - Forwarding per source: EX/MEM wins over MEM/WB; a producer is matched only if reg_write=1,
//    rd==rs and rd!=0; otherwise the registered regfile data is used. x0 is never forwarded.
//  - ex_op1 = use_pc ? pc : fwd_rs1; ex_op2 = use_imm ? imm : fwd_rs2; ex_store_data = fwd_rs2.
//  - load_use_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd |
//    (!id_use_imm & id_rs2==ex_rd)).
//  - id_ready = !load_use_stall & (!ex_valid | ex_ready).
//  - Update, in priority order:
//    flush: ex_valid<=0, no capture.
//    else id_valid & id_ready: capture, ex_valid<=1.
//    else ex_ready | !ex_valid: ex_valid<=0, i.e. bubble, including on load_use_stall.
//    else hold: ex_valid and control unchanged; stored rs1/rs2 data overwritten with fwd_rs1/fwd_rs2
//    each cycle so operands stay correct after producers retire.
//  - Load-use: exactly one bubble cycle when the load is consumed (ex_ready=1); longer while ex_ready=0.
//  - Flush during a load-use stall clears the load's slot; id_ready recomputes next cycle.
//  - Reset asserted mid-operation: immediate clear to reset values; no partial capture.
//  - All arithmetic is pass-through; no width changes; indices compared at REGW bits.
// TESTING
//  1. Reset with id_valid=1 -> ex_valid=0, ex_op1=ex_op2=0; first cycle after release captures.
//  2. ADD x3,x1,x2 (rs data 5,7), no producers -> next cycle ex_op1=5, ex_op2=7, ex_alu_op=0010.
//  3. exmem rd=1 result=0x10 and memwb rd=1 result=0x20, rs1=1 -> ex_op1=0x10; exmem rd=0 -> no fwd.
//  4. LW x4 in EX, decode SUB x5,x4,x6 -> load_use_stall=1, id_ready=0, one bubble (ex_valid=0),
//     then SUB captured with memwb forwarding of x4.
//  5. ex_ready=0 for 3 cycles while MEM/WB forwards x2=0x55 then retires -> ex_op2 stays 0x55.
//  6. flush with id_valid=1 and id_ready=1 -> ex_valid=0 next cycle, decode instruction not captured.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Also detects load-use hazards and handles the valid/ready handshake on both sides.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_use_imm,
  input  logic            id_use_pc,
  input  logic [3:0]      id_alu_op,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_reg_write,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [3:0]      ex_alu_op,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            load_use_stall
);

  logic            ex_valid_q,     ex_valid_d;
  logic [REGW-1:0] rs1_idx_q,      rs1_idx_d;
  logic [REGW-1:0] rs2_idx_q,      rs2_idx_d;
  logic [XLEN-1:0] rs1_data_q,     rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,     rs2_data_d;
  logic [XLEN-1:0] imm_q,          imm_d;
  logic [XLEN-1:0] pc_q,           pc_d;
  logic            use_imm_q,      use_imm_d;
  logic            use_pc_q,       use_pc_d;
  logic [3:0]      alu_op_q,       alu_op_d;
  logic [REGW-1:0] rd_q,           rd_d;
  logic            reg_write_q,    reg_write_d;
  logic            mem_read_q,     mem_read_d;

  logic            exmem_hit_rs1, exmem_hit_rs2;
  logic            memwb_hit_rs1, memwb_hit_rs2;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  logic            capture;

  // A producer matches only when it writes a non-zero rd equal to the source index.
  always_comb begin
    exmem_hit_rs1 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_idx_q);
    exmem_hit_rs2 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_idx_q);
    memwb_hit_rs1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_idx_q);
    memwb_hit_rs2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_idx_q);

    if (exmem_hit_rs1)      fwd_rs1 = exmem_result;
    else if (memwb_hit_rs1) fwd_rs1 = memwb_result;
    else                    fwd_rs1 = rs1_data_q;

    if (exmem_hit_rs2)      fwd_rs2 = exmem_result;
    else if (memwb_hit_rs2) fwd_rs2 = memwb_result;
    else                    fwd_rs2 = rs2_data_q;
  end

  always_comb begin
    load_use_stall = ex_valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                     ((id_rs1 == rd_q) || (!id_use_imm && (id_rs2 == rd_q)));
    id_ready       = !load_use_stall && (!ex_valid_q || ex_ready);
    capture        = id_valid && id_ready;
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    use_imm_d   = use_imm_q;
    use_pc_d    = use_pc_q;
    alu_op_d    = alu_op_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;

    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (capture) begin
      ex_valid_d  = 1'b1;
      rs1_idx_d   = id_rs1;
      rs2_idx_d   = id_rs2;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      pc_d        = id_pc;
      use_imm_d   = id_use_imm;
      use_pc_d    = id_use_pc;
      alu_op_d    = id_alu_op;
      rd_d        = id_rd;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
    end else if (ex_ready || !ex_valid_q) begin
      ex_valid_d = 1'b0;
    end else begin
      // Stalled downstream: absorb forwarded values so they survive producer retirement.
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      alu_op_q    <= 4'b0000;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      use_imm_q   <= use_imm_d;
      use_pc_q    <= use_pc_d;
      alu_op_q    <= alu_op_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  always_comb begin
    ex_valid      = ex_valid_q;
    ex_op1        = use_pc_q  ? pc_q  : fwd_rs1;
    ex_op2        = use_imm_q ? imm_q : fwd_rs2;
    ex_store_data = fwd_rs2;
    ex_alu_op     = alu_op_q;
    ex_rd         = rd_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
  end

endmodule
